// File: rtl/memory_lsu_pkg.sv
// Shared decode constants, FSM state type and request-decode helpers for the load/store unit.
// Build option: MEMORY_LSU_MISALIGN_SPLIT_EN turns on two-beat handling of word-crossing accesses.
package memory_lsu_pkg;

  localparam logic [1:0] MEM_OP_NONE = 2'b00;
  localparam logic [1:0] MEM_OP_LD   = 2'b01;
  localparam logic [1:0] MEM_OP_ST   = 2'b10;

  localparam logic [2:0] MEM_FUNCT_LB  = 3'b000;
  localparam logic [2:0] MEM_FUNCT_LH  = 3'b001;
  localparam logic [2:0] MEM_FUNCT_LW  = 3'b010;
  localparam logic [2:0] MEM_FUNCT_LD  = 3'b011;
  localparam logic [2:0] MEM_FUNCT_LBU = 3'b100;
  localparam logic [2:0] MEM_FUNCT_LHU = 3'b101;
  localparam logic [2:0] MEM_FUNCT_LWU = 3'b110;
  localparam logic [2:0] MEM_FUNCT_SD  = 3'b011;

`ifdef MEMORY_LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD0,
    ST_WAIT0,
    ST_CMD1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_t;

  // Access size as log2(bytes) lives in the low two funct3 bits.
  function automatic logic [1:0] funct_size_log2(input logic [2:0] funct);
    return funct[1:0];
  endfunction

  function automatic logic funct_legal(input logic [1:0] op, input logic [2:0] funct, input int xlen);
    if (funct == 3'b111) return 1'b0;
    if (op == MEM_OP_ST && funct[2]) return 1'b0;
    if (xlen == 32 && (funct[1:0] == 2'b11 || funct == MEM_FUNCT_LWU)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/memory_lsu_if.sv
// Request/response and bus-port signal bundle of the load/store unit; slave is the LSU side.
interface memory_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            mem_op_i;
  logic [2:0]            mem_funct_i;
  logic [ADDR_W-1:0]     mem_addr_i;
  logic [XLEN-1:0]       mem_wdata_i;
  logic                  resp_valid_o;
  logic [XLEN-1:0]       resp_rdata_o;
  logic                  resp_err_o;
  logic                  bus_valid_o;
  logic                  bus_ready_i;
  logic [ADDR_W-OFS-1:0] bus_addr_o;
  logic [NB-1:0]         bus_wen_o;
  logic                  bus_ren_o;
  logic [XLEN-1:0]       bus_wdata_o;
  logic                  bus_rvalid_i;
  logic [XLEN-1:0]       bus_rdata_i;

  modport slave (
    input  req_valid_i, mem_op_i, mem_funct_i, mem_addr_i, mem_wdata_i,
           bus_ready_i, bus_rvalid_i, bus_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           bus_valid_o, bus_addr_o, bus_wen_o, bus_ren_o, bus_wdata_o
  );

  modport master (
    output req_valid_i, mem_op_i, mem_funct_i, mem_addr_i, mem_wdata_i,
           bus_ready_i, bus_rvalid_i, bus_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           bus_valid_o, bus_addr_o, bus_wen_o, bus_ren_o, bus_wdata_o
  );
endinterface

// File: rtl/memory_lane_align.sv
// Combinational byte-lane steering: store strobes/data per beat, and load byte merge plus extension.
// Works on a double-width window so a word-crossing access is just the upper half for beat 1.
module memory_lane_align #(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OFS = $clog2(NB)
) (
  input  logic [2:0]      funct,
  input  logic [OFS-1:0]  offset,
  input  logic            beat,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata_lo,
  input  logic [XLEN-1:0] rdata_hi,
  output logic [NB-1:0]   wen,
  output logic [XLEN-1:0] wdata_lane,
  output logic [XLEN-1:0] rdata_ext
);

  logic [2*NB-1:0]   mask_wide;
  logic [2*NB-1:0]   strb_wide;
  logic [2*XLEN-1:0] data_wide;
  logic [XLEN-1:0]   rd_shift;
  logic              sign_bit;
  logic              fill;

  always_comb begin
    case (funct[1:0])
      2'd0:    mask_wide = (2*NB)'(8'h01);
      2'd1:    mask_wide = (2*NB)'(8'h03);
      2'd2:    mask_wide = (2*NB)'(8'h0F);
      default: mask_wide = (2*NB)'(8'hFF);
    endcase
  end

  assign strb_wide  = mask_wide << offset;
  assign data_wide  = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
  assign wen        = beat ? strb_wide[2*NB-1:NB] : strb_wide[NB-1:0];
  assign wdata_lane = beat ? data_wide[2*XLEN-1:XLEN] : data_wide[XLEN-1:0];

  assign rd_shift = XLEN'({rdata_hi, rdata_lo} >> {offset, 3'b000});

  always_comb begin
    case (funct[1:0])
      2'd0:    sign_bit = rd_shift[7];
      2'd1:    sign_bit = rd_shift[15];
      2'd2:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[XLEN-1];
    endcase
  end

  assign fill = sign_bit & ~funct[2];

  // Bytes inside the access keep their data, everything above is the extension bit.
  for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
    assign rdata_ext[gi] = mask_wide[gi/8] ? rd_shift[gi] : fill;
  end

endmodule

// File: rtl/memory_lsu.sv
// MEM-stage load/store unit: request capture, bus command/wait FSM, beat-0 read holding and response regs.
// With MEMORY_LSU_MISALIGN_SPLIT_EN word-crossing accesses run as two beats, otherwise they fail with err.
module memory_lsu
  import memory_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  localparam int NB    = XLEN / 8,
  localparam int OFS   = $clog2(NB)
) (
  input logic        clk_i,
  input logic        rst_i,
  memory_lsu_if.slave lsu
);

  lsu_state_t        state_reg, state_next;
  logic [1:0]        op_reg;
  logic [2:0]        funct_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic              split_reg;
  logic [XLEN-1:0]   hold_reg;
  logic [XLEN-1:0]   rdata_reg;
  logic              err_reg;

  logic            acc_mem, acc_legal, acc_cross, acc_fail;
  logic            is_load, beat, bus_cmd, last_rd;
  logic [NB-1:0]   align_wen;
  logic [XLEN-1:0] align_wdata, align_rdata, rd_lo, rd_hi;

  assign acc_mem   = (lsu.mem_op_i == MEM_OP_LD) || (lsu.mem_op_i == MEM_OP_ST);
  assign acc_legal = funct_legal(lsu.mem_op_i, lsu.mem_funct_i, XLEN);
  assign acc_cross = (int'(lsu.mem_addr_i[OFS-1:0]) + (1 << funct_size_log2(lsu.mem_funct_i))) > NB;
  assign acc_fail  = acc_mem && (!acc_legal || (acc_cross && !SPLIT_EN));

  assign is_load = (op_reg == MEM_OP_LD);
  assign beat    = (state_reg == ST_CMD1) || (state_reg == ST_WAIT1);
  assign bus_cmd = (state_reg == ST_CMD0) || (state_reg == ST_CMD1);
  assign last_rd = lsu.bus_rvalid_i &&
                   (((state_reg == ST_WAIT0) && !split_reg) || (state_reg == ST_WAIT1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (lsu.req_valid_i) state_next = (!acc_mem || acc_fail) ? ST_RESP : ST_CMD0;
      ST_CMD0:  if (lsu.bus_ready_i)
                  state_next = is_load ? ST_WAIT0 : (split_reg ? ST_CMD1 : ST_RESP);
      ST_WAIT0: if (lsu.bus_rvalid_i) state_next = split_reg ? ST_CMD1 : ST_RESP;
      ST_CMD1:  if (lsu.bus_ready_i) state_next = is_load ? ST_WAIT1 : ST_RESP;
      ST_WAIT1: if (lsu.bus_rvalid_i) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      op_reg    <= MEM_OP_NONE;
      funct_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      split_reg <= 1'b0;
      hold_reg  <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && lsu.req_valid_i) begin
        op_reg    <= lsu.mem_op_i;
        funct_reg <= lsu.mem_funct_i;
        addr_reg  <= lsu.mem_addr_i;
        wdata_reg <= lsu.mem_wdata_i;
        split_reg <= acc_mem && acc_legal && acc_cross && SPLIT_EN;
        err_reg   <= acc_fail;
        hold_reg  <= '0;
        rdata_reg <= '0;
      end
      if (state_reg == ST_WAIT0 && lsu.bus_rvalid_i) hold_reg <= lsu.bus_rdata_i;
      if (last_rd) rdata_reg <= align_rdata;
    end
  end

  // Beat 1 merges the held low word with the arriving high word.
  assign rd_lo = (state_reg == ST_WAIT1) ? hold_reg : lsu.bus_rdata_i;
  assign rd_hi = (state_reg == ST_WAIT1) ? lsu.bus_rdata_i : '0;

  memory_lane_align #(.XLEN(XLEN)) u_align (
    .funct      (funct_reg),
    .offset     (addr_reg[OFS-1:0]),
    .beat       (beat),
    .wdata      (wdata_reg),
    .rdata_lo   (rd_lo),
    .rdata_hi   (rd_hi),
    .wen        (align_wen),
    .wdata_lane (align_wdata),
    .rdata_ext  (align_rdata)
  );

  assign lsu.req_ready_o  = (state_reg == ST_IDLE);
  assign lsu.resp_valid_o = (state_reg == ST_RESP);
  assign lsu.resp_rdata_o = rdata_reg;
  assign lsu.resp_err_o   = err_reg;
  assign lsu.bus_valid_o  = bus_cmd;
  assign lsu.bus_ren_o    = bus_cmd && is_load;
  assign lsu.bus_addr_o   = addr_reg[ADDR_W-1:OFS] + (ADDR_W-OFS)'(beat);
  assign lsu.bus_wen_o    = (bus_cmd && !is_load) ? align_wen : '0;
  assign lsu.bus_wdata_o  = (bus_cmd && !is_load) ? align_wdata : '0;

endmodule

// File: tb/tb_memory_lsu.sv
// Directed bench for memory_lsu: one 32-bit and one 64-bit instance, hand-computed expectations.
module tb_memory_lsu;
  import memory_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  memory_lsu_if #(.XLEN(32), .ADDR_W(32)) if32 ();
  memory_lsu_if #(.XLEN(64), .ADDR_W(32)) if64 ();

  memory_lsu #(.XLEN(32), .ADDR_W(32)) u32 (.clk_i(clk), .rst_i(rst), .lsu(if32));
  memory_lsu #(.XLEN(64), .ADDR_W(32)) u64 (.clk_i(clk), .rst_i(rst), .lsu(if64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue32(input logic [1:0] op, input logic [2:0] funct,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if32.req_valid_i = 1'b1;
    if32.mem_op_i    = op;
    if32.mem_funct_i = funct;
    if32.mem_addr_i  = addr;
    if32.mem_wdata_i = wdata;
    cyc(1);
    if32.req_valid_i = 1'b0;
  endtask

  task automatic issue64(input logic [1:0] op, input logic [2:0] funct,
                         input logic [31:0] addr, input logic [63:0] wdata);
    if64.req_valid_i = 1'b1;
    if64.mem_op_i    = op;
    if64.mem_funct_i = funct;
    if64.mem_addr_i  = addr;
    if64.mem_wdata_i = wdata;
    cyc(1);
    if64.req_valid_i = 1'b0;
  endtask

  initial begin
    if32.req_valid_i = 0; if32.mem_op_i = 0; if32.mem_funct_i = 0; if32.mem_addr_i = 0;
    if32.mem_wdata_i = 0; if32.bus_ready_i = 0; if32.bus_rvalid_i = 0; if32.bus_rdata_i = 0;
    if64.req_valid_i = 0; if64.mem_op_i = 0; if64.mem_funct_i = 0; if64.mem_addr_i = 0;
    if64.mem_wdata_i = 0; if64.bus_ready_i = 0; if64.bus_rvalid_i = 0; if64.bus_rdata_i = 0;

    cyc(2);
    check("rst_ready", if32.req_ready_o, 1);
    check("rst_resp", if32.resp_valid_o, 0);
    check("rst_err", if32.resp_err_o, 0);
    check("rst_bvalid", if32.bus_valid_o, 0);
    check("rst_ren", if32.bus_ren_o, 0);
    check("rst_wen", if32.bus_wen_o, 0);
    rst = 1'b0;
    cyc(1);
    $display("txn reset");

    // SB 0x1003 <- 0xA5, zero-wait bus
    if32.bus_ready_i = 1'b1;
    issue32(MEM_OP_ST, MEM_FUNCT_LB, 32'h1003, 32'hA5);
    check("sb_valid", if32.bus_valid_o, 1);
    check("sb_addr", if32.bus_addr_o, 30'h400);
    check("sb_wen", if32.bus_wen_o, 4'b1000);
    check("sb_wdata", if32.bus_wdata_o, 32'hA500_0000);
    check("sb_ren", if32.bus_ren_o, 0);
    check("sb_ready_busy", if32.req_ready_o, 0);
    cyc(1);
    check("sb_resp", if32.resp_valid_o, 1);
    check("sb_rdata", if32.resp_rdata_o, 0);
    check("sb_err", if32.resp_err_o, 0);
    check("sb_bus_idle", if32.bus_valid_o, 0);
    cyc(1);
    check("sb_resp_pulse", if32.resp_valid_o, 0);
    check("sb_ready_back", if32.req_ready_o, 1);
    $display("txn SB 0x1003");

    // LH 0x2002, bus stalls command 2 cycles, data 3 cycles late
    if32.bus_ready_i = 1'b0;
    issue32(MEM_OP_LD, MEM_FUNCT_LH, 32'h2002, 32'h0);
    check("lh_valid", if32.bus_valid_o, 1);
    check("lh_ren", if32.bus_ren_o, 1);
    check("lh_wen", if32.bus_wen_o, 0);
    cyc(2);
    check("lh_hold_valid", if32.bus_valid_o, 1);
    check("lh_hold_addr", if32.bus_addr_o, 30'h800);
    if32.bus_ready_i = 1'b1;
    cyc(1);
    if32.bus_ready_i = 1'b0;
    check("lh_wait_valid", if32.bus_valid_o, 0);
    cyc(2);
    check("lh_no_early_resp", if32.resp_valid_o, 0);
    if32.bus_rvalid_i = 1'b1;
    if32.bus_rdata_i  = 32'h8001_1234;
    cyc(1);
    if32.bus_rvalid_i = 1'b0;
    check("lh_resp", if32.resp_valid_o, 1);
    check("lh_rdata", if32.resp_rdata_o, 32'hFFFF_8001);
    check("lh_err", if32.resp_err_o, 0);
    cyc(1);
    $display("txn LH 0x2002");

    // LHU 0x1001: unaligned but inside one word
    if32.bus_ready_i = 1'b1;
    issue32(MEM_OP_LD, MEM_FUNCT_LHU, 32'h1001, 32'h0);
    check("lhu_addr", if32.bus_addr_o, 30'h400);
    cyc(1);
    if32.bus_rvalid_i = 1'b1;
    if32.bus_rdata_i  = 32'h00AB_CD00;
    cyc(1);
    if32.bus_rvalid_i = 1'b0;
    check("lhu_resp", if32.resp_valid_o, 1);
    check("lhu_rdata", if32.resp_rdata_o, 32'h0000_ABCD);
    check("lhu_err", if32.resp_err_o, 0);
    cyc(1);
    $display("txn LHU 0x1001");

    // LW 0x0006 crosses a word boundary
    issue32(MEM_OP_LD, MEM_FUNCT_LW, 32'h0006, 32'h0);
`ifdef MEMORY_LSU_MISALIGN_SPLIT_EN
    check("lwx_b0_addr", if32.bus_addr_o, 30'h1);
    check("lwx_b0_ren", if32.bus_ren_o, 1);
    cyc(1);
    if32.bus_rvalid_i = 1'b1;
    if32.bus_rdata_i  = 32'h3322_ABCD;
    cyc(1);
    if32.bus_rvalid_i = 1'b0;
    check("lwx_b1_valid", if32.bus_valid_o, 1);
    check("lwx_b1_addr", if32.bus_addr_o, 30'h2);
    cyc(1);
    if32.bus_rvalid_i = 1'b1;
    if32.bus_rdata_i  = 32'h1234_5544;
    cyc(1);
    if32.bus_rvalid_i = 1'b0;
    check("lwx_resp", if32.resp_valid_o, 1);
    check("lwx_rdata", if32.resp_rdata_o, 32'h5544_3322);
    check("lwx_err", if32.resp_err_o, 0);
`else
    check("lwx_resp", if32.resp_valid_o, 1);
    check("lwx_err", if32.resp_err_o, 1);
    check("lwx_rdata", if32.resp_rdata_o, 0);
    check("lwx_no_bus", if32.bus_valid_o, 0);
`endif
    cyc(1);
    $display("txn LW 0x0006 crossing");

    // SH 0xFFFFFFFF crosses the top of the address space
    issue32(MEM_OP_ST, MEM_FUNCT_LH, 32'hFFFF_FFFF, 32'h0000_BEEF);
`ifdef MEMORY_LSU_MISALIGN_SPLIT_EN
    check("shx_b0_addr", if32.bus_addr_o, 30'h3FFF_FFFF);
    check("shx_b0_wen", if32.bus_wen_o, 4'b1000);
    check("shx_b0_wdata", if32.bus_wdata_o, 32'hEF00_0000);
    cyc(1);
    check("shx_b1_addr", if32.bus_addr_o, 30'h0);
    check("shx_b1_wen", if32.bus_wen_o, 4'b0001);
    check("shx_b1_wdata", if32.bus_wdata_o, 32'h0000_00BE);
    cyc(1);
    check("shx_resp", if32.resp_valid_o, 1);
    check("shx_err", if32.resp_err_o, 0);
`else
    check("shx_resp", if32.resp_valid_o, 1);
    check("shx_err", if32.resp_err_o, 1);
    check("shx_no_bus", if32.bus_valid_o, 0);
`endif
    cyc(1);
    $display("txn SH 0xFFFFFFFF crossing");

    // Illegal funct on 32-bit and op none
    issue32(MEM_OP_LD, MEM_FUNCT_LD, 32'h0000_0010, 32'h0);
    check("ld32_resp", if32.resp_valid_o, 1);
    check("ld32_err", if32.resp_err_o, 1);
    check("ld32_no_bus", if32.bus_valid_o, 0);
    cyc(1);
    issue32(MEM_OP_ST, 3'b100, 32'h0000_0010, 32'h1);
    check("stbad_resp", if32.resp_valid_o, 1);
    check("stbad_err", if32.resp_err_o, 1);
    cyc(1);
    issue32(MEM_OP_NONE, MEM_FUNCT_LW, 32'h0000_0003, 32'h0);
    check("none_resp", if32.resp_valid_o, 1);
    check("none_err", if32.resp_err_o, 0);
    check("none_rdata", if32.resp_rdata_o, 0);
    check("none_no_bus", if32.bus_valid_o, 0);
    cyc(1);
    $display("txn illegal/none");

    // Reset while waiting for read data, then stale rvalid
    issue32(MEM_OP_LD, MEM_FUNCT_LW, 32'h0000_0010, 32'h0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rstmid_ready", if32.req_ready_o, 1);
    check("rstmid_bus", if32.bus_valid_o, 0);
    if32.bus_rvalid_i = 1'b1;
    if32.bus_rdata_i  = 32'hFFFF_FFFF;
    cyc(1);
    if32.bus_rvalid_i = 1'b0;
    check("rstmid_no_resp", if32.resp_valid_o, 0);
    check("rstmid_ready2", if32.req_ready_o, 1);
    cyc(1);
    check("rstmid_no_resp2", if32.resp_valid_o, 0);
    $display("txn reset mid-load");

    // 64-bit: LWU 0x4 and SD 0x8
    if64.bus_ready_i = 1'b1;
    issue64(MEM_OP_LD, MEM_FUNCT_LWU, 32'h0000_0004, 64'h0);
    check("lwu_addr", if64.bus_addr_o, 29'h0);
    check("lwu_ren", if64.bus_ren_o, 1);
    cyc(1);
    if64.bus_rvalid_i = 1'b1;
    if64.bus_rdata_i  = 64'h8000_0001_DEAD_BEEF;
    cyc(1);
    if64.bus_rvalid_i = 1'b0;
    check("lwu_resp", if64.resp_valid_o, 1);
    check("lwu_rdata", if64.resp_rdata_o, 64'h0000_0000_8000_0001);
    check("lwu_err", if64.resp_err_o, 0);
    cyc(1);
    issue64(MEM_OP_ST, MEM_FUNCT_SD, 32'h0000_0008, 64'h0123_4567_89AB_CDEF);
    check("sd_addr", if64.bus_addr_o, 29'h1);
    check("sd_wen", if64.bus_wen_o, 8'hFF);
    check("sd_wdata", if64.bus_wdata_o, 64'h0123_4567_89AB_CDEF);
    cyc(1);
    check("sd_resp", if64.resp_valid_o, 1);
    check("sd_err", if64.resp_err_o, 0);
    cyc(1);
    $display("txn XLEN64 LWU/SD");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
